prbs16_checker: RTL and testbench
=================================

PRBS16_CHECKER -- requirements
Module: prbs16_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 32: consecutive correct predictions required to declare lock.
REQ-002 SHALL have parameter WINDOW, default 64: accepted-bit window length while locked.
REQ-003 SHALL have parameter LOSS_ERRS, default 4: errors within one window that cause loss of lock.
REQ-004 SHALL have one clock; reset is synchronous and active-high (ports clk, reset).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  checker enable; low forces re-acquisition.
REQ-008 rx_bit  input  1  received serial bit; this is the new bit0 of the 16-bit generator.
REQ-009 rx_valid  input  1  qualifies rx_bit; one bit is accepted per cycle with rx_valid=1.
REQ-010 clr_cnt  input  1  clears err_count.
REQ-011 locked  output  1  high while in LOCKED state.
REQ-012 bit_err  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-013 err_count  output  16  saturating count of LOCKED-state mismatches.
REQ-014 state  output  2  current state encoding: FILL=0, VERIFY=1, LOCKED=2.

Function
REQ-015 The generator model SHALL be next = {r[14:0], fb}, with fb = XNOR(r[15], r[14], r[12], r[3]). The received bit is the generator's fb.
REQ-016 FILL: each accepted bit SHALL shift into r. After 16 accepted bits the state SHALL go to VERIFY.
REQ-017 VERIFY: each accepted bit SHALL be compared with the predicted fb(r) and shifted into r.
- A match increments the match count.
- A mismatch clears the match count and returns to FILL with the fill count set to 0.
REQ-018 VERIFY SHALL return to FILL when r == 16'hFFFF (the XNOR lockup value). Lock is never declared on the lockup value.
REQ-019 When the LOCK_COUNT-th consecutive match is accepted, the state SHALL go to LOCKED. locked rises on the following cycle.
REQ-020 LOCKED: r SHALL advance with the predicted fb, not with rx_bit, so received errors never corrupt the local sequence.
REQ-021 LOCKED: a mismatch SHALL pulse bit_err for exactly one cycle, the cycle after acceptance, and SHALL increment the window error count and err_count.
REQ-022 The window counter SHALL count accepted bits 0..WINDOW-1 and wrap. The window error count clears at the wrap.
REQ-023 An error on the last bit of a window SHALL be counted and checked against LOSS_ERRS before the window clears.
REQ-024 When the window error count reaches LOSS_ERRS, the state SHALL go to FILL. locked falls the next cycle and the fill count is 0.
REQ-025 err_count SHALL saturate at 16'hFFFF.
REQ-026 clr_cnt SHALL set err_count to 0. If clr_cnt and a counted error coincide, err_count SHALL become 1.
REQ-027 Cycles with rx_valid=0 SHALL change no state, counter, or r. bit_err SHALL be 0 on the cycle after such a cycle.
REQ-028 en=0 SHALL force FILL with fill, match, and window counts at 0, and bit_err at 0. err_count SHALL be held.

Reset
REQ-029 reset SHALL set, on the next clk edge:
- state FILL
- r = 0
- all counters 0
- locked = 0, bit_err = 0, err_count = 0
REQ-030 reset SHALL take priority over en, clr_cnt, and rx_valid, including in the middle of a lock or window.

Structure
REQ-031 A shared package lfsr_pkg SHALL hold:
- LFSR width 16
- tap positions 15, 14, 12, 3
- the lockup constant 16'hFFFF
- the state enum (FILL, VERIFY, LOCKED)
REQ-032 The feedback function SHALL be one combinational sub-module, lfsr16_next (r in, fb out). It is reusable by the 16-bit generator.

Verification
REQ-033 Clean stream from a generator reset to 0 (first bits 1,1,1,1,0), rx_valid=1 every cycle -> locked rises one cycle after the 48th accepted bit; err_count=0 after 1000 bits.
REQ-034 rx_valid=1 only every 4th cycle -> lock after 48 accepted bits; state is frozen on idle cycles.
REQ-035 Locked, then rx_bit inverted on three isolated bits -> three bit_err pulses; err_count=3; locked stays 1; later bits are correct (no error propagation).
REQ-036 Locked, then 4 inverted bits within one 64-bit window -> locked falls on the cycle after the 4th error; state is FILL; relock occurs after 48 clean bits.
REQ-037 Constant rx_bit=1 stream -> never locked; state cycles FILL/VERIFY.
REQ-038 clr_cnt coincident with an error -> err_count=1. Reset asserted while locked -> all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit XNOR PRBS generator/checker family.
package lfsr_pkg;

    localparam int LFSR_W = 16;

    // Feedback tap positions of the x^16 + x^15 + x^13 + x^4 + 1 polynomial.
    localparam int TAP_A = 15;
    localparam int TAP_B = 14;
    localparam int TAP_C = 12;
    localparam int TAP_D = 3;

    // Tap positions folded into a mask so the feedback is a single reduction.
    localparam logic [LFSR_W-1:0] TAP_MASK = LFSR_W'((1 << TAP_A) | (1 << TAP_B) |
                                                     (1 << TAP_C) | (1 << TAP_D));

    // With XNOR feedback the all-ones register maps onto itself.
    localparam logic [LFSR_W-1:0] LOCKUP = 16'hFFFF;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

endpackage

// File: rtl/lfsr16_next.sv
// Combinational feedback bit of the 16-bit XNOR LFSR; shared with the generator.
module lfsr16_next
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] r,
    output logic              fb
);

    // XNOR of the tapped bits equals the inverted parity of the masked register.
    assign fb = ~(^(r & TAP_MASK));

endmodule

// File: rtl/prbs16_checker.sv
// PRBS16 receive checker: self-synchronises to the incoming stream, then
// free-runs its local generator and counts bit errors, dropping lock when
// too many errors fall inside one window.
module prbs16_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 32,
    parameter int WINDOW     = 64,
    parameter int LOSS_ERRS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        rx_bit,
    input  logic        rx_valid,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        bit_err,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    localparam int FW = $clog2(LFSR_W + 1);
    localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(LOSS_ERRS + 1);

    localparam logic [FW-1:0] FILL_LAST  = FW'(LFSR_W - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] LOSS_LIM   = EW'(LOSS_ERRS);

    chk_state_e        state_p1;
    logic [LFSR_W-1:0] r_p1;
    logic [FW-1:0]     fill_p1;
    logic [MW-1:0]     match_p1;
    logic [WW-1:0]     win_p1;
    logic [EW-1:0]     werr_p1;
    logic              bit_err_p1;
    logic [15:0]       err_cnt_p1;

    logic              fb_pred;
    logic              mismatch;
    logic              err_hit;
    logic [LFSR_W-1:0] r_shift;
    logic [LFSR_W-1:0] r_pred;
    logic [EW-1:0]     werr_inc;

    lfsr16_next u_next (
        .r  (r_p1),
        .fb (fb_pred)
    );

    assign mismatch = rx_bit ^ fb_pred;
    assign r_shift  = {r_p1[LFSR_W-2:0], rx_bit};
    assign r_pred   = {r_p1[LFSR_W-2:0], fb_pred};
    assign werr_inc = werr_p1 + 1'b1;
    assign err_hit  = en && rx_valid && (state_p1 == LOCKED) && mismatch;

    // Acquisition / tracking state machine with its fill, match and window counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= FILL;
            r_p1     <= '0;
            fill_p1  <= '0;
            match_p1 <= '0;
            win_p1   <= '0;
            werr_p1  <= '0;
        end else if (!en) begin
            state_p1 <= FILL;
            fill_p1  <= '0;
            match_p1 <= '0;
            win_p1   <= '0;
            werr_p1  <= '0;
        end else if (rx_valid) begin
            case (state_p1)
                FILL: begin
                    r_p1 <= r_shift;
                    if (fill_p1 == FILL_LAST) begin
                        state_p1 <= VERIFY;
                        fill_p1  <= '0;
                    end else begin
                        fill_p1 <= fill_p1 + 1'b1;
                    end
                end
                VERIFY: begin
                    r_p1 <= r_shift;
                    // The lockup value would predict itself forever, so never lock on it.
                    if (mismatch || (r_shift == LOCKUP)) begin
                        state_p1 <= FILL;
                        fill_p1  <= '0;
                        match_p1 <= '0;
                    end else if (match_p1 == MATCH_LAST) begin
                        state_p1 <= LOCKED;
                        match_p1 <= '0;
                        win_p1   <= '0;
                        werr_p1  <= '0;
                    end else begin
                        match_p1 <= match_p1 + 1'b1;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so line errors cannot corrupt the reference.
                    r_p1 <= r_pred;
                    if (mismatch && (werr_inc == LOSS_LIM)) begin
                        state_p1 <= FILL;
                        fill_p1  <= '0;
                        win_p1   <= '0;
                        werr_p1  <= '0;
                    end else if (win_p1 == WIN_LAST) begin
                        win_p1  <= '0;
                        werr_p1 <= '0;
                    end else begin
                        win_p1 <= win_p1 + 1'b1;
                        if (mismatch) begin
                            werr_p1 <= werr_inc;
                        end
                    end
                end
                default: begin
                    state_p1 <= FILL;
                    fill_p1  <= '0;
                    match_p1 <= '0;
                end
            endcase
        end
    end

    // Error pulse and saturating error counter; clear wins over increment but keeps a coincident error.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_err_p1 <= 1'b0;
            err_cnt_p1 <= '0;
        end else begin
            bit_err_p1 <= err_hit;
            if (clr_cnt) begin
                err_cnt_p1 <= err_hit ? 16'd1 : 16'd0;
            end else if (err_hit && (err_cnt_p1 != 16'hFFFF)) begin
                err_cnt_p1 <= err_cnt_p1 + 16'd1;
            end
        end
    end

    assign locked    = (state_p1 == LOCKED);
    assign bit_err   = bit_err_p1;
    assign err_count = err_cnt_p1;
    assign state     = state_p1;

endmodule

// File: tb/tb_prbs16_checker.sv
// Scoreboard bench for prbs16_checker with default parameters.
module tb_prbs16_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        rx_bit;
    logic        rx_valid;
    logic        clr_cnt;
    logic        locked;
    logic        bit_err;
    logic [15:0] err_count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    logic [15:0] g;

    typedef struct packed {
        logic       lk;
        logic       be;
        logic [1:0] st;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    prbs16_checker dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .bit_err   (bit_err),
        .err_count (err_count),
        .state     (state)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic gfb(input logic [15:0] r);
        return ~(r[15] ^ r[14] ^ r[12] ^ r[3]);
    endfunction

    task automatic gen(output logic b);
        b = gfb(g);
        g = {g[14:0], b};
    endtask

    // Expected outputs after n clean accepted bits since the last restart.
    function automatic exp_t acq_exp(input int n);
        exp_t e;
        e.be = 1'b0;
        if (n >= 48) begin
            e.lk = 1'b1; e.st = 2'd2;
        end else if (n >= 16) begin
            e.lk = 1'b0; e.st = 2'd1;
        end else begin
            e.lk = 1'b0; e.st = 2'd0;
        end
        return e;
    endfunction

    task automatic tick(input logic b, input logic v);
        rx_bit   = b;
        rx_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        en      = 1'b1;
        clr_cnt = 1'b0;
        tick(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic acquire;
        logic b;
        for (int i = 0; i < 48; i++) begin
            gen(b);
            tick(b, 1'b1);
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        en      = 1'b1;
        clr_cnt = 1'b1;
        tick(1'b1, 1'b1);
        checks++;
        if ({locked, bit_err, state} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got lk=%b be=%b st=%0d want all 0", locked, bit_err, state);
        end
        checks++;
        if (err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_err_count: got %0d want 0", err_count);
        end
        reset   = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic test_clean_stream;
        logic b;
        exp_t e, got;
        do_reset();
        g = 16'h0000;
        for (int i = 1; i <= 1000; i++) begin
            gen(b);
            sbq.push_back(acq_exp(i));
            tick(b, 1'b1);
            got = {locked, bit_err, state};
            e = sbq.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL clean_stream bit %0d: got lk=%b be=%b st=%0d want lk=%b be=%b st=%0d",
                         i, got.lk, got.be, got.st, e.lk, e.be, e.st);
            end
        end
        checks++;
        if (err_count !== 16'd0) begin
            errors++;
            $display("FAIL clean_err_count: got %0d want 0", err_count);
        end
    endtask

    task automatic test_sparse_valid;
        logic b;
        int n;
        int unsigned rnd;
        exp_t e, got;
        do_reset();
        n = 0;
        for (int c = 0; c < 48 * 4 + 16; c++) begin
            if ((c % 4) == 3) begin
                gen(b);
                n++;
                sbq.push_back(acq_exp(n));
                tick(b, 1'b1);
            end else begin
                rnd = $urandom;
                sbq.push_back(acq_exp(n));
                tick(rnd[0], 1'b0);
            end
            got = {locked, bit_err, state};
            e = sbq.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL sparse_valid cyc %0d: got lk=%b be=%b st=%0d want lk=%b be=%b st=%0d",
                         c, got.lk, got.be, got.st, e.lk, e.be, e.st);
            end
        end
    endtask

    task automatic test_isolated_errors;
        logic b, err;
        exp_t e, got;
        do_reset();
        acquire();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL isolated_lock: got locked=%b want 1", locked);
        end
        for (int j = 0; j < 100; j++) begin
            gen(b);
            err = (j == 10) || (j == 30) || (j == 50);
            sbq.push_back('{lk: 1'b1, be: err, st: 2'd2});
            tick(b ^ err, 1'b1);
            got = {locked, bit_err, state};
            e = sbq.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL isolated_errors j %0d: got lk=%b be=%b st=%0d want lk=%b be=%b st=%0d",
                         j, got.lk, got.be, got.st, e.lk, e.be, e.st);
            end
        end
        checks++;
        if (err_count !== 16'd3) begin
            errors++;
            $display("FAIL isolated_err_count: got %0d want 3", err_count);
        end
    endtask

    task automatic test_window_wrap;
        logic b, err;
        exp_t e, got;
        do_reset();
        acquire();
        for (int j = 0; j <= 191; j++) begin
            gen(b);
            err = (j == 61) || (j == 62) || (j == 63) || (j == 64) || (j == 65) ||
                  (j == 66) || (j == 128) || (j == 129) || (j == 130) || (j == 191);
            if (j < 191) sbq.push_back('{lk: 1'b1, be: err, st: 2'd2});
            else         sbq.push_back('{lk: 1'b0, be: 1'b1, st: 2'd0});
            tick(b ^ err, 1'b1);
            got = {locked, bit_err, state};
            e = sbq.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL window_wrap j %0d: got lk=%b be=%b st=%0d want lk=%b be=%b st=%0d",
                         j, got.lk, got.be, got.st, e.lk, e.be, e.st);
            end
        end
        checks++;
        if (err_count !== 16'd10) begin
            errors++;
            $display("FAIL window_err_count: got %0d want 10", err_count);
        end
    endtask

    task automatic test_loss_relock;
        logic b, err;
        exp_t e, got;
        do_reset();
        acquire();
        for (int j = 0; j <= 20; j++) begin
            gen(b);
            err = (j == 5) || (j == 10) || (j == 15) || (j == 20);
            if (j < 20) sbq.push_back('{lk: 1'b1, be: err, st: 2'd2});
            else        sbq.push_back('{lk: 1'b0, be: 1'b1, st: 2'd0});
            tick(b ^ err, 1'b1);
            got = {locked, bit_err, state};
            e = sbq.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL loss j %0d: got lk=%b be=%b st=%0d want lk=%b be=%b st=%0d",
                         j, got.lk, got.be, got.st, e.lk, e.be, e.st);
            end
        end
        for (int n = 1; n <= 60; n++) begin
            gen(b);
            sbq.push_back(acq_exp(n));
            tick(b, 1'b1);
            got = {locked, bit_err, state};
            e = sbq.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL relock bit %0d: got lk=%b be=%b st=%0d want lk=%b be=%b st=%0d",
                         n, got.lk, got.be, got.st, e.lk, e.be, e.st);
            end
        end
        checks++;
        if (err_count !== 16'd4) begin
            errors++;
            $display("FAIL loss_err_count: got %0d want 4", err_count);
        end
    endtask

    task automatic test_const_ones;
        exp_t e, got;
        do_reset();
        for (int i = 1; i <= 120; i++) begin
            sbq.push_back('{lk: 1'b0, be: 1'b0, st: ((i % 17) == 16) ? 2'd1 : 2'd0});
            tick(1'b1, 1'b1);
            got = {locked, bit_err, state};
            e = sbq.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL const_ones bit %0d: got lk=%b be=%b st=%0d want lk=%b be=%b st=%0d",
                         i, got.lk, got.be, got.st, e.lk, e.be, e.st);
            end
        end
    endtask

    task automatic test_clr_en_reset;
        logic b, err;
        do_reset();
        acquire();
        for (int j = 0; j < 10; j++) begin
            gen(b);
            err = (j == 3) || (j == 7);
            tick(b ^ err, 1'b1);
            checks++;
            if (bit_err !== err) begin
                errors++;
                $display("FAIL clr_pre_err j %0d: got be=%b want %b", j, bit_err, err);
            end
        end
        // Disable with a corrupted bit: drops to FILL, no pulse, count held.
        gen(b);
        en = 1'b0;
        tick(~b, 1'b1);
        en = 1'b1;
        checks++;
        if ({locked, bit_err, state} !== 4'b0000 || err_count !== 16'd2) begin
            errors++;
            $display("FAIL en_low: got lk=%b be=%b st=%0d cnt=%0d want 0 0 0 2",
                     locked, bit_err, state, err_count);
        end
        acquire();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL en_relock: got locked=%b want 1", locked);
        end
        // Clear coincident with a counted error.
        gen(b);
        clr_cnt = 1'b1;
        tick(~b, 1'b1);
        clr_cnt = 1'b0;
        checks++;
        if (err_count !== 16'd1 || bit_err !== 1'b1) begin
            errors++;
            $display("FAIL clr_with_err: got cnt=%0d be=%b want 1 1", err_count, bit_err);
        end
        gen(b);
        clr_cnt = 1'b1;
        tick(b, 1'b1);
        clr_cnt = 1'b0;
        checks++;
        if (err_count !== 16'd0) begin
            errors++;
            $display("FAIL clr_alone: got cnt=%0d want 0", err_count);
        end
        gen(b);
        tick(~b, 1'b1);
        checks++;
        if (err_count !== 16'd1) begin
            errors++;
            $display("FAIL pre_reset_err: got cnt=%0d want 1", err_count);
        end
        // Reset while locked beats a live valid bit with an error.
        gen(b);
        reset = 1'b1;
        tick(~b, 1'b1);
        reset = 1'b0;
        checks++;
        if ({locked, bit_err, state} !== 4'b0000 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_locked: got lk=%b be=%b st=%0d cnt=%0d want all 0",
                     locked, bit_err, state, err_count);
        end
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        rx_bit   = 1'b0;
        rx_valid = 1'b0;
        clr_cnt  = 1'b0;
        g        = 16'h0000;
        test_reset();
        test_clean_stream();
        test_sparse_valid();
        test_isolated_errors();
        test_window_wrap();
        test_loss_relock();
        test_const_ones();
        test_clr_en_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
